// File: rtl/arbitro_peatonal.sv
// Pedestrian-crossing scheduler: latches button requests, grants one walk window at a time while the crossed street is red.
// Optional macro PEATONAL_FLASH_EN: the served walk output blinks during clearance instead of staying low.
module arbitro_peatonal #(
  parameter int WALK_CYC  = 8,
  parameter int CLEAR_CYC = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enb,
  input  logic       btn_A,
  input  logic       btn_B,
  input  logic [1:0] semaforo_A,
  input  logic [1:0] semaforo_B,
  output logic       Apeatonal,
  output logic       Bpeatonal,
  output logic       pend_A,
  output logic       pend_B
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_RED = 2'd1,
    S_WALK     = 2'd2,
    S_CLEAR    = 2'd3
  } state_e;

  localparam logic SIDE_A = 1'b0;
  localparam logic SIDE_B = 1'b1;

  localparam int TMAX = (WALK_CYC > CLEAR_CYC) ? WALK_CYC : CLEAR_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] T_ZERO  = TW'(0);
  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [TW-1:0] T_WALK  = TW'(WALK_CYC - 1);
  localparam logic [TW-1:0] T_CLEAR = TW'(CLEAR_CYC - 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            sel_q, sel_d;
  logic            last_grant_q, last_grant_d;
  logic            pend_a_q, pend_a_d;
  logic            pend_b_q, pend_b_d;
  logic            btn_a_q, btn_b_q;
  logic            walk_a_q, walk_a_d;
  logic            walk_b_q, walk_b_d;

  logic            sel_red_s;
  logic            grant_s;
  logic            busy_s;
  logic            rise_a_s;
  logic            rise_b_s;
  logic            flash_s;

  assign sel_red_s = (sel_q == SIDE_A) ? (semaforo_A == 2'b00) : (semaforo_B == 2'b00);
  assign grant_s   = enb && (state_q == S_WAIT_RED) && sel_red_s;
  assign busy_s    = (state_q == S_WALK) || (state_q == S_CLEAR);
  assign rise_a_s  = btn_A && !btn_a_q;
  assign rise_b_s  = btn_B && !btn_b_q;

  // State, timer, request and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      timer_q      <= T_ZERO;
      sel_q        <= SIDE_A;
      last_grant_q <= SIDE_B;
      pend_a_q     <= 1'b0;
      pend_b_q     <= 1'b0;
      btn_a_q      <= 1'b0;
      btn_b_q      <= 1'b0;
      walk_a_q     <= 1'b0;
      walk_b_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      pend_a_q     <= pend_a_d;
      pend_b_q     <= pend_b_d;
      btn_a_q      <= btn_A;
      btn_b_q      <= btn_B;
      walk_a_q     <= walk_a_d;
      walk_b_q     <= walk_b_d;
    end
  end

  // Next-state: FSM sequencing, timer and request latches
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;

    if (enb) begin
      case (state_q)
        S_IDLE: begin
          if (pend_a_q || pend_b_q) begin
            state_d = S_WAIT_RED;
            if (pend_a_q && pend_b_q) begin
              sel_d = ~last_grant_q;
            end else if (pend_a_q) begin
              sel_d = SIDE_A;
            end else begin
              sel_d = SIDE_B;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WAIT_RED: begin
          if (sel_red_s) begin
            state_d = S_WALK;
            timer_d = T_WALK;
          end else begin
            state_d = S_WAIT_RED;
          end
        end
        S_WALK: begin
          // A light leaving red cuts the walk short
          if (!sel_red_s || (timer_q == T_ZERO)) begin
            state_d = S_CLEAR;
            timer_d = T_CLEAR;
          end else begin
            timer_d = timer_q - T_ONE;
          end
        end
        S_CLEAR: begin
          if (timer_q == T_ZERO) begin
            state_d      = S_IDLE;
            last_grant_d = sel_q;
          end else begin
            timer_d = timer_q - T_ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          timer_d = T_ZERO;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (grant_s && (sel_q == SIDE_A)) begin
      pend_a_d = 1'b0;
    end else if (rise_a_s && !(busy_s && (sel_q == SIDE_A))) begin
      pend_a_d = 1'b1;
    end else begin
      pend_a_d = pend_a_q;
    end

    if (grant_s && (sel_q == SIDE_B)) begin
      pend_b_d = 1'b0;
    end else if (rise_b_s && !(busy_s && (sel_q == SIDE_B))) begin
      pend_b_d = 1'b1;
    end else begin
      pend_b_d = pend_b_q;
    end
  end

  // Output: walk lines follow the next state, only the served side is driven
  always_comb begin
    walk_a_d = 1'b0;
    walk_b_d = 1'b0;
    flash_s  = 1'b0;
    if (state_d == S_WALK) begin
      walk_a_d = (sel_d == SIDE_A);
      walk_b_d = (sel_d == SIDE_B);
    end else if (state_d == S_CLEAR) begin
`ifdef PEATONAL_FLASH_EN
      if (state_q == S_CLEAR) begin
        flash_s = enb ? ~(walk_a_q | walk_b_q) : (walk_a_q | walk_b_q);
      end else begin
        flash_s = 1'b0;
      end
`else
      flash_s = 1'b0;
`endif
      walk_a_d = flash_s && (sel_d == SIDE_A);
      walk_b_d = flash_s && (sel_d == SIDE_B);
    end else begin
      walk_a_d = 1'b0;
      walk_b_d = 1'b0;
    end
  end

  assign Apeatonal = walk_a_q;
  assign Bpeatonal = walk_b_q;
  assign pend_A    = pend_a_q;
  assign pend_B    = pend_b_q;

endmodule

// File: tb/tb_arbitro_peatonal.sv
// Bench for arbitro_peatonal: per-cycle vector table with a scoreboard queue, plus a hand-written async reset sequence.
module tb_arbitro_peatonal;

  logic       clk = 1'b0;
  logic       reset;
  logic       enb;
  logic       btn_A;
  logic       btn_B;
  logic [1:0] semaforo_A;
  logic [1:0] semaforo_B;
  logic       Apeatonal;
  logic       Bpeatonal;
  logic       pend_A;
  logic       pend_B;

  arbitro_peatonal #(.WALK_CYC(8), .CLEAR_CYC(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .enb        (enb),
    .btn_A      (btn_A),
    .btn_B      (btn_B),
    .semaforo_A (semaforo_A),
    .semaforo_B (semaforo_B),
    .Apeatonal  (Apeatonal),
    .Bpeatonal  (Bpeatonal),
    .pend_A     (pend_A),
    .pend_B     (pend_B)
  );

  always #5 clk = ~clk;

  // exp = {Apeatonal, Bpeatonal, pend_A, pend_B} after the edge that samples the row's inputs
  typedef struct {
    int         n;
    logic       en;
    logic       ba;
    logic       bb;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [3:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] sb_q[$];
  int         errors = 0;
  int         checks = 0;

  function automatic void add(int n, logic en, logic ba, logic bb,
                              logic [1:0] sa, logic [1:0] sb, logic [3:0] e);
    vec_t v;
    v.n = n; v.en = en; v.ba = ba; v.bb = bb; v.sa = sa; v.sb = sb; v.exp = e;
    tbl.push_back(v);
  endfunction

  // Three clearance cycles after a walk on side_b (0 = A, 1 = B)
  function automatic void add_clear(logic [1:0] sa, logic [1:0] sb, logic side_b,
                                    logic pa, logic pb);
`ifdef PEATONAL_FLASH_EN
    add(1, 1'b1, 1'b0, 1'b0, sa, sb, {2'b00, pa, pb});
    add(1, 1'b1, 1'b0, 1'b0, sa, sb, {~side_b, side_b, pa, pb});
    add(1, 1'b1, 1'b0, 1'b0, sa, sb, {2'b00, pa, pb});
`else
    add(3, 1'b1, 1'b0, 1'b0, sa, sb, {2'b00, pa, pb});
`endif
  endfunction

  task automatic check(string name, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {A,B,pA,pB}=%b expected %b", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single A, light red: latency 2, 8 walk, 3 clear
    add(1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 4'b0010);
    add(1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 4'b0010);
    add(8, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 4'b1000);
    add_clear(2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
    add(1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 4'b0000);
    // B waits for red
    add(1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b01, 4'b0001);
    add(3, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 4'b0001);
    add(8, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0100);
    add_clear(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    add(1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000);
    // Tie after B served: A first, then B
    add(2, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 4'b0011);
    add(8, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b1001);
    add_clear(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    add(2, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0001);
    add(8, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0100);
    add_clear(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    add(1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000);
    // Single A, then a tie goes to B first
    add(1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 4'b0010);
    add(1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0010);
    add(8, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b1000);
    add_clear(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    add(1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000);
    add(1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 4'b0011);
    add(1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0011);
    add(8, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0110);
    add_clear(2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    add(2, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0010);
    add(8, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b1000);
    add_clear(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    add(1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000);
    // Abort: A light goes yellow during the 4th walk cycle; B queued meanwhile
    add(1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 4'b0010);
    add(1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0010);
    add(3, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b1000);
    add(1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 4'b1001);
    add_clear(2'b10, 2'b00, 1'b0, 1'b0, 1'b1);
    add(2, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0001);
    add(8, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0100);
    add_clear(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    add(1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000);
    // enb gating mid-walk: 8+5 walk cycles, A edge dropped, B captured while frozen
    add(1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 4'b0010);
    add(1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0010);
    add(3, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b1000);
    add(1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 4'b1000);
    add(1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 4'b1001);
    add(3, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b1001);
    add(5, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b1001);
    add_clear(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    add(2, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0001);
    add(8, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0100);
    add_clear(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    add(1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000);

    // Reset state, including a button press ignored while held in reset
    reset = 1'b0; enb = 1'b1; btn_A = 1'b0; btn_B = 1'b0;
    semaforo_A = 2'b00; semaforo_B = 2'b00;
    #1;
    check("reset_init", {Apeatonal, Bpeatonal, pend_A, pend_B}, 4'b0000);
    @(negedge clk); btn_A = 1'b1;
    @(negedge clk); btn_A = 1'b0;
    check("reset_hold", {Apeatonal, Bpeatonal, pend_A, pend_B}, 4'b0000);
    @(negedge clk); reset = 1'b1;

    // Async reset in the middle of a walk with B pending
    btn_A = 1'b1;
    @(negedge clk); btn_A = 1'b0;
    check("rst_seq_pend", {Apeatonal, Bpeatonal, pend_A, pend_B}, 4'b0010);
    @(negedge clk);
    @(negedge clk);
    check("rst_seq_walk", {Apeatonal, Bpeatonal, pend_A, pend_B}, 4'b1000);
    btn_B = 1'b1;
    @(posedge clk); #2;
    check("rst_seq_pendB", {Apeatonal, Bpeatonal, pend_A, pend_B}, 4'b1001);
    reset = 1'b0; btn_B = 1'b0;
    #1;
    check("rst_midwalk", {Apeatonal, Bpeatonal, pend_A, pend_B}, 4'b0000);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("rst_release", {Apeatonal, Bpeatonal, pend_A, pend_B}, 4'b0000);

    // Table: drive on the falling edge, expectation queued, compared after the rising edge
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        logic [3:0] e;
        @(negedge clk);
        enb = tbl[i].en; btn_A = tbl[i].ba; btn_B = tbl[i].bb;
        semaforo_A = tbl[i].sa; semaforo_B = tbl[i].sb;
        sb_q.push_back(tbl[i].exp);
        @(posedge clk); #1;
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty row%0d.%0d: got empty queue expected one entry", i, k);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("row%0d.%0d", i, k), {Apeatonal, Bpeatonal, pend_A, pend_B}, e);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
